// File: rtl/instr_fetch.sv
// Instruction fetch unit: 12-bit FetchPC, 1-cycle-latency memory reads, 2-entry instruction FIFO.
// Optional 4-entry return stack with Call/Ret/StackErr when INSTR_FETCH_CALL_STACK_EN is defined.
module instr_fetch (
  input  logic        CLK,
  input  logic        RST,
  output logic [11:0] MemAddr,
  output logic        MemRd,
  input  logic [15:0] MemData,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [11:0] JumpAddr,
`ifdef INSTR_FETCH_CALL_STACK_EN
  input  logic        Call,
  input  logic        Ret,
  output logic        StackErr,
`endif
  output logic [15:0] Instr,
  output logic        InstrValid,
  output logic [11:0] InstrPC
);

  logic [11:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] fifo_data_q [2];
  logic [11:0] fifo_pc_q [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic        inflight_q, inflight_d;
  logic [11:0] inflight_addr_q, inflight_addr_d;

  logic        pop, push, mem_rd, wr_idx;
  logic [2:0]  occupancy;
  logic        redirect;
  logic [11:0] redirect_addr;
  logic [11:0] head_pc;

  assign head_pc = fifo_pc_q[head_q];
  assign wr_idx  = head_q ^ count_q[0];

`ifdef INSTR_FETCH_CALL_STACK_EN
  logic [11:0] stk_q [4];
  logic [11:0] stk_d [4];
  logic [1:0]  sp_q, sp_d;
  logic [2:0]  scnt_q, scnt_d;
  logic        err_q, err_d;
  logic        call_go, ret_go;
  logic [11:0] ret_addr;

  assign call_go  = Call & ~Jump;
  assign ret_go   = Ret & ~Jump & ~Call;
  assign StackErr = err_q;

  // Circular buffer: when full, the slot at sp_q holds the oldest entry, so a push overwrites it.
  always_comb begin
    stk_d    = stk_q;
    sp_d     = sp_q;
    scnt_d   = scnt_q;
    err_d    = err_q;
    ret_addr = '0;
    if (scnt_q != 3'd0) ret_addr = stk_q[sp_q - 2'd1];
    if (call_go) begin
      stk_d[sp_q] = head_pc + 12'd1;
      sp_d        = sp_q + 2'd1;
      if (scnt_q == 3'd4) err_d = 1'b1;
      else                scnt_d = scnt_q + 3'd1;
    end else if (ret_go) begin
      if (scnt_q == 3'd0) begin
        err_d = 1'b1;
      end else begin
        sp_d   = sp_q - 2'd1;
        scnt_d = scnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sp_q   <= '0;
      scnt_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) stk_q[i] <= '0;
    end else begin
      sp_q   <= sp_d;
      scnt_q <= scnt_d;
      err_q  <= err_d;
      stk_q  <= stk_d;
    end
  end

  assign redirect      = Jump | Call | Ret;
  assign redirect_addr = (Jump | Call) ? JumpAddr : ret_addr;
`else
  assign redirect      = Jump;
  assign redirect_addr = JumpAddr;
`endif

  assign InstrValid = ~RST & (count_q != 2'd0);
  assign Instr      = RST ? '0 : fifo_data_q[head_q];
  assign InstrPC    = RST ? '0 : head_pc;
  assign MemAddr    = RST ? '0 : fetch_pc_q;
  assign MemRd      = mem_rd;

  always_comb begin
    pop       = InstrValid & ~Stall;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    mem_rd    = ~RST & ~redirect & (occupancy < 3'd2);
    // The word returning this cycle belongs to a stale stream if a redirect is in progress.
    push      = inflight_q & ~redirect & ~RST;

    inflight_d      = mem_rd;
    inflight_addr_d = fetch_pc_q;

    fetch_pc_d = fetch_pc_q;
    if (redirect)    fetch_pc_d = redirect_addr;
    else if (mem_rd) fetch_pc_d = fetch_pc_q + 12'd1;

    if (redirect) begin
      count_d = '0;
      head_d  = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      head_d  = head_q ^ pop;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q      <= '0;
      head_q          <= 1'b0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      head_q          <= head_d;
      count_q         <= count_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      if (push) begin
        fifo_data_q[wr_idx] <= MemData;
        fifo_pc_q[wr_idx]   <= inflight_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; memory model returns 0x1000+addr one cycle after a read.
// Return-stack scenario is compiled in when INSTR_FETCH_CALL_STACK_EN is defined.
module tb_instr_fetch;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] MemAddr;
  logic        MemRd;
  logic [15:0] MemData = 16'hDEAD;
  logic        Stall = 1'b0;
  logic        Jump = 1'b0;
  logic [11:0] JumpAddr = '0;
  logic [15:0] Instr;
  logic        InstrValid;
  logic [11:0] InstrPC;
`ifdef INSTR_FETCH_CALL_STACK_EN
  logic        Call = 1'b0;
  logic        Ret = 1'b0;
  logic        StackErr;
`endif

  int errors = 0;
  int checks = 0;

  logic        rd_s = 1'b0;
  logic [11:0] addr_s = '0;

  instr_fetch dut (
    .CLK(CLK), .RST(RST), .MemAddr(MemAddr), .MemRd(MemRd), .MemData(MemData),
    .Stall(Stall), .Jump(Jump), .JumpAddr(JumpAddr),
`ifdef INSTR_FETCH_CALL_STACK_EN
    .Call(Call), .Ret(Ret), .StackErr(StackErr),
`endif
    .Instr(Instr), .InstrValid(InstrValid), .InstrPC(InstrPC)
  );

  always #5 CLK = ~CLK;

  // Request captured mid-cycle; data is returned during the following cycle.
  always @(negedge CLK) begin
    #3;
    rd_s   = MemRd;
    addr_s = MemAddr;
  end
  always @(posedge CLK) MemData <= rd_s ? (16'h1000 + {4'h0, addr_s}) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic expect_instr(input string tag, input logic [11:0] pc);
    check({tag, ".valid"}, 32'(InstrValid), 32'(1));
    check({tag, ".pc"}, 32'(InstrPC), 32'(pc));
    check({tag, ".instr"}, 32'(Instr), 32'(16'h1000 + {4'h0, pc}));
  endtask

  task automatic expect_empty(input string tag);
    check({tag, ".valid"}, 32'(InstrValid), 32'(0));
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, ".memrd"}, 32'(MemRd), 32'(0));
    check({tag, ".memaddr"}, 32'(MemAddr), 32'(0));
    check({tag, ".valid"}, 32'(InstrValid), 32'(0));
    check({tag, ".instr"}, 32'(Instr), 32'(0));
    check({tag, ".pc"}, 32'(InstrPC), 32'(0));
  endtask

  initial begin
    tick(); tick(); #1;
    expect_reset_outputs("rst");

    // Reset release and streaming
    tick(); RST = 1'b0; #1;
    check("rel.memrd", 32'(MemRd), 32'(1));
    check("rel.memaddr", 32'(MemAddr), 32'(0));
    tick(); #1; expect_empty("rel+1");
    for (int i = 0; i < 3; i++) begin
      tick(); #1; expect_instr("stream", 12'(i));
    end

    // Stall with head at 0x003
    tick(); Stall = 1'b1; #1;
    expect_instr("stall0", 12'h003);
    check("stall0.memrd", 32'(MemRd), 32'(0));
    for (int k = 1; k < 5; k++) begin
      tick(); #1;
      expect_instr("stall", 12'h003);
      check("stall.memrd", 32'(MemRd), 32'(0));
    end
    tick(); Stall = 1'b0; #1;
    expect_instr("unstall", 12'h003);
    check("unstall.memrd", 32'(MemRd), 32'(1));
    tick(); #1; expect_instr("after_stall", 12'h004);
    tick(); #1; expect_instr("after_stall", 12'h005);

    // Jump while stalled with the FIFO full
    tick(); Stall = 1'b1; #1;
    expect_instr("fill", 12'h006);
    tick(); Jump = 1'b1; JumpAddr = 12'h0A0; #1;
    expect_instr("full", 12'h006);
    check("jump.memrd", 32'(MemRd), 32'(0));
    tick(); Jump = 1'b0; Stall = 1'b0; #1;
    check("jump+1.memrd", 32'(MemRd), 32'(1));
    check("jump+1.memaddr", 32'(MemAddr), 32'(12'h0A0));
    expect_empty("jump+1");
    tick(); #1; expect_empty("jump+2");
    tick(); #1; expect_instr("jump+3", 12'h0A0);
    tick(); #1; expect_instr("jump+4", 12'h0A1);

    // Jump during consumption, then back-to-back jumps (last wins)
    tick(); Jump = 1'b1; JumpAddr = 12'h100; #1;
    expect_instr("jpop", 12'h0A2);
    tick(); JumpAddr = 12'h200; #1;
    check("jj.memrd", 32'(MemRd), 32'(0));
    tick(); Jump = 1'b0; #1;
    check("jj+1.memaddr", 32'(MemAddr), 32'(12'h200));
    check("jj+1.memrd", 32'(MemRd), 32'(1));
    expect_empty("jj+1");
    tick(); #1; expect_empty("jj+2");
    tick(); #1; expect_instr("jj+3", 12'h200);

    // Address wrap
    tick(); Jump = 1'b1; JumpAddr = 12'hFFE; #1;
    tick(); Jump = 1'b0; #1;
    tick(); #1;
    tick(); #1; expect_instr("wrap", 12'hFFE);
    tick(); #1; expect_instr("wrap", 12'hFFF);
    tick(); #1; expect_instr("wrap", 12'h000);

    // Reset with a read in flight
    tick(); RST = 1'b1; #1;
    expect_reset_outputs("rst_mid");
    tick(); RST = 1'b0; #1;
    expect_empty("rst_mid+1");
    check("rst_mid+1.memrd", 32'(MemRd), 32'(1));
    check("rst_mid+1.memaddr", 32'(MemAddr), 32'(0));
    tick(); #1; expect_empty("rst_mid+2");
    tick(); #1; expect_instr("rst_mid+3", 12'h000);

    // Reset with the FIFO full
    tick(); Stall = 1'b1; #1;
    expect_instr("rst_full_fill", 12'h001);
    tick(); RST = 1'b1; #1;
    expect_reset_outputs("rst_full");
    tick(); RST = 1'b0; Stall = 1'b0; #1;
    expect_empty("rst_full+1");
    check("rst_full+1.memaddr", 32'(MemAddr), 32'(0));
    check("rst_full+1.memrd", 32'(MemRd), 32'(1));
    tick(); #1; expect_empty("rst_full+2");
    tick(); #1; expect_instr("rst_full+3", 12'h000);
    tick(); #1; expect_instr("rst_full+4", 12'h001);

`ifdef INSTR_FETCH_CALL_STACK_EN
    check("stk.err_init", 32'(StackErr), 32'(0));
    tick(); Jump = 1'b1; JumpAddr = 12'h010; #1;
    tick(); Jump = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    for (int c = 0; c < 5; c++) begin
      expect_instr("call_at", 12'(12'h010 + c));
      Call = 1'b1; JumpAddr = 12'(12'h011 + c);
      tick(); Call = 1'b0; #1;
      check("call.memaddr", 32'(MemAddr), 32'(12'h011 + c));
      check("call.err", 32'(StackErr), 32'(c == 4));
      tick(); #1;
      tick(); #1;
    end
    begin
      logic [11:0] ret_exp [5];
      ret_exp[0] = 12'h015; ret_exp[1] = 12'h014; ret_exp[2] = 12'h013;
      ret_exp[3] = 12'h012; ret_exp[4] = 12'h000;
      for (int r = 0; r < 5; r++) begin
        Ret = 1'b1;
        tick(); Ret = 1'b0; #1;
        check("ret.memaddr", 32'(MemAddr), 32'(ret_exp[r]));
        check("ret.memrd", 32'(MemRd), 32'(1));
        check("ret.err", 32'(StackErr), 32'(1));
        tick(); #1;
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
